// File: rtl/core_pkg.sv
// Shared definitions for the fetch front end.
//   pc_state_e    : PC generator boot/run state encoding
//   INSTR_STEP_*  : sequential PC increments for 32-bit and 16-bit instructions
//   is_compressed : instruction length decode from the two low opcode bits
package core_pkg;

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } pc_state_e;

    localparam int unsigned INSTR_STEP_32 = 4;
    localparam int unsigned INSTR_STEP_16 = 2;

    // RVC: any low opcode pair other than 2'b11 marks a 16-bit instruction.
    function automatic logic is_compressed(input logic [1:0] lo);
        return (lo != 2'b11);
    endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC priority mux with alignment check. Purely combinational.
// Priority: trap > redirect > stall > accepted fetch > hold.
// Ports:
//   pc_i             current PC
//   stall_i          hold request
//   redirect_valid_i / redirect_pc_i   branch/jump target
//   trap_valid_i     / trap_pc_i       trap entry / return target
//   fetch_fire_i     fetch accepted this cycle (tie to 1 in a single-cycle core)
//   instr_lo_i       low opcode bits of the instruction at pc_i
//   pc_next_o        selected next PC
//   misalign_o       selected target was misaligned and has been rejected
module pc_next_sel
    import core_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter bit          C_EXT = 1'b1
) (
    input  logic [XLEN-1:0] pc_i,
    input  logic            stall_i,
    input  logic            redirect_valid_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    input  logic            trap_valid_i,
    input  logic [XLEN-1:0] trap_pc_i,
    input  logic            fetch_fire_i,
    input  logic [1:0]      instr_lo_i,
    output logic [XLEN-1:0] pc_next_o,
    output logic            misalign_o
);

    logic [XLEN-1:0] tgt;
    logic            tgt_vld;
    logic            tgt_bad;
    logic [XLEN-1:0] step;

    // Trap wins over redirect; a dropped redirect is simply not seen.
    always_comb begin
        tgt     = '0;
        tgt_vld = 1'b0;
        if (trap_valid_i) begin
            tgt     = trap_pc_i;
            tgt_vld = 1'b1;
        end else if (redirect_valid_i) begin
            tgt     = redirect_pc_i;
            tgt_vld = 1'b1;
        end
    end

    // Halfword alignment always; word alignment without the C extension.
    assign tgt_bad = tgt[0] | (!C_EXT && tgt[1]);

    assign step = (C_EXT && is_compressed(instr_lo_i)) ? XLEN'(INSTR_STEP_16)
                                                       : XLEN'(INSTR_STEP_32);

    always_comb begin
        pc_next_o  = pc_i;
        misalign_o = 1'b0;
        if (tgt_vld) begin
            if (tgt_bad) misalign_o = 1'b1;
            else         pc_next_o  = tgt;
        end else if (!stall_i && fetch_fire_i) begin
            pc_next_o = pc_i + step;  // wraps modulo 2^XLEN
        end
    end

endmodule

// File: rtl/pc_gen.sv
// IF-stage fetch program-counter generator.
// One BOOT cycle after reset (no request, redirects ignored), then RUN with a
// continuously valid fetch request. pc_o and misalign_o are registered.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   stall_i           hold PC
//   redirect_valid_i / redirect_pc_i   branch/jump redirect
//   trap_valid_i     / trap_pc_i       trap / mret redirect (wins over redirect)
//   instr_lo_i        low opcode bits of the instruction fetched at pc_o
//   fetch_valid_o     request valid to IMEM
//   fetch_ready_i     IMEM accepts request
//   pc_o              current fetch PC
//   misalign_o        one-cycle pulse: rejected misaligned target
module pc_gen
    import core_pkg::*;
#(
    parameter int unsigned     XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter bit              C_EXT        = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall_i,
    input  logic            redirect_valid_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    input  logic            trap_valid_i,
    input  logic [XLEN-1:0] trap_pc_i,
    input  logic [1:0]      instr_lo_i,
    output logic            fetch_valid_o,
    input  logic            fetch_ready_i,
    output logic [XLEN-1:0] pc_o,
    output logic            misalign_o
);

    pc_state_e       state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            misalign_q, misalign_d;
    logic [XLEN-1:0] sel_pc;
    logic            sel_misalign;

    pc_next_sel #(
        .XLEN  (XLEN),
        .C_EXT (C_EXT)
    ) u_sel (
        .pc_i             (pc_q),
        .stall_i          (stall_i),
        .redirect_valid_i (redirect_valid_i),
        .redirect_pc_i    (redirect_pc_i),
        .trap_valid_i     (trap_valid_i),
        .trap_pc_i        (trap_pc_i),
        .fetch_fire_i     (fetch_valid_o & fetch_ready_i),
        .instr_lo_i       (instr_lo_i),
        .pc_next_o        (sel_pc),
        .misalign_o       (sel_misalign)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= BOOT;
            pc_q       <= RESET_VECTOR;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            misalign_q <= misalign_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        misalign_d    = 1'b0;
        fetch_valid_o = 1'b0;
        unique case (state_q)
            BOOT: begin
                // Redirect/trap inputs are not looked at here.
                state_d = RUN;
            end
            RUN: begin
                fetch_valid_o = 1'b1;
                pc_d          = sel_pc;
                misalign_d    = sel_misalign;
            end
            default: state_d = BOOT;
        endcase
    end

    assign pc_o       = pc_q;
    assign misalign_o = misalign_q;

endmodule

// File: tb/tb_pc_gen.sv
module tb_pc_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall_i, redirect_valid_i, trap_valid_i, fetch_ready_i;
    logic [31:0] redirect_pc_i, trap_pc_i;
    logic [1:0]  instr_lo_i;
    logic        vld_c, vld_w, mis_c, mis_w;
    logic [31:0] pc_c, pc_w;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Compressed-enabled instance
    pc_gen #(.XLEN(32), .RESET_VECTOR(32'h0000_1000), .C_EXT(1'b1)) dut_c (
        .clk(clk), .rst_n(rst_n), .stall_i(stall_i),
        .redirect_valid_i(redirect_valid_i), .redirect_pc_i(redirect_pc_i),
        .trap_valid_i(trap_valid_i), .trap_pc_i(trap_pc_i),
        .instr_lo_i(instr_lo_i), .fetch_valid_o(vld_c),
        .fetch_ready_i(fetch_ready_i), .pc_o(pc_c), .misalign_o(mis_c)
    );

    // Word-only instance
    pc_gen #(.XLEN(32), .RESET_VECTOR(32'h0000_1000), .C_EXT(1'b0)) dut_w (
        .clk(clk), .rst_n(rst_n), .stall_i(stall_i),
        .redirect_valid_i(redirect_valid_i), .redirect_pc_i(redirect_pc_i),
        .trap_valid_i(trap_valid_i), .trap_pc_i(trap_pc_i),
        .instr_lo_i(instr_lo_i), .fetch_valid_o(vld_w),
        .fetch_ready_i(fetch_ready_i), .pc_o(pc_w), .misalign_o(mis_w)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_both(input string tag, input logic [31:0] pc_exp_c, input logic [31:0] pc_exp_w,
                            input logic vld_exp, input logic mis_exp_c, input logic mis_exp_w);
        chk({tag, ".pc_c"},  pc_c,  pc_exp_c);
        chk({tag, ".pc_w"},  pc_w,  pc_exp_w);
        chk({tag, ".vld_c"}, {31'd0, vld_c}, {31'd0, vld_exp});
        chk({tag, ".vld_w"}, {31'd0, vld_w}, {31'd0, vld_exp});
        chk({tag, ".mis_c"}, {31'd0, mis_c}, {31'd0, mis_exp_c});
        chk({tag, ".mis_w"}, {31'd0, mis_w}, {31'd0, mis_exp_w});
    endtask

    task automatic drive(input logic st, input logic rdy, input logic [1:0] lo,
                         input logic rv, input logic [31:0] rpc,
                         input logic tv, input logic [31:0] tpc);
        stall_i = st; fetch_ready_i = rdy; instr_lo_i = lo;
        redirect_valid_i = rv; redirect_pc_i = rpc;
        trap_valid_i = tv; trap_pc_i = tpc;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 2'b11, 1'b0, 32'h0, 1'b0, 32'h0);
        #12;
        chk_both("reset", 32'h1000, 32'h1000, 1'b0, 1'b0, 1'b0);

        // Release; BOOT cycle ignores a redirect.
        @(posedge clk); #1;
        rst_n = 1'b1;
        drive(1'b0, 1'b1, 2'b11, 1'b1, 32'h5000, 1'b0, 32'h0);
        #1;
        chk_both("boot", 32'h1000, 32'h1000, 1'b0, 1'b0, 1'b0);
        step();
        chk_both("run0", 32'h1000, 32'h1000, 1'b1, 1'b0, 1'b0);

        // Sequential mix 11,01,11
        drive(1'b0, 1'b1, 2'b11, 1'b0, 32'h0, 1'b0, 32'h0); step();
        chk_both("seq1", 32'h1004, 32'h1004, 1'b1, 1'b0, 1'b0);
        instr_lo_i = 2'b01; step();
        chk_both("seq2", 32'h1006, 32'h1008, 1'b1, 1'b0, 1'b0);
        instr_lo_i = 2'b11; step();
        chk_both("seq3", 32'h100A, 32'h100C, 1'b1, 1'b0, 1'b0);

        // Redirect with ready low still lands
        drive(1'b0, 1'b0, 2'b11, 1'b1, 32'h2000, 1'b0, 32'h0); step();
        chk_both("redir_nrdy", 32'h2000, 32'h2000, 1'b1, 1'b0, 1'b0);

        // Backpressure for 3 cycles
        redirect_valid_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_both("bp", 32'h2000, 32'h2000, 1'b1, 1'b0, 1'b0);
        end

        // Stall with ready high holds
        drive(1'b1, 1'b1, 2'b11, 1'b0, 32'h0, 1'b0, 32'h0); step();
        chk_both("stall", 32'h2000, 32'h2000, 1'b1, 1'b0, 1'b0);

        // Trap beats redirect and stall
        drive(1'b1, 1'b1, 2'b11, 1'b1, 32'h3000, 1'b1, 32'h8000_0000); step();
        chk_both("trap_prio", 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0, 1'b0);

        // Redirect alone during stall
        drive(1'b1, 1'b1, 2'b11, 1'b1, 32'h3000, 1'b0, 32'h0); step();
        chk_both("redir_stall", 32'h3000, 32'h3000, 1'b1, 1'b0, 1'b0);

        // Odd target rejected by both; no sequential advance either
        drive(1'b0, 1'b1, 2'b11, 1'b1, 32'h3001, 1'b0, 32'h0); step();
        chk_both("mis_odd", 32'h3000, 32'h3000, 1'b1, 1'b1, 1'b1);

        // Halfword target: accepted only with C
        redirect_pc_i = 32'h3002; step();
        chk_both("mis_half", 32'h3002, 32'h3000, 1'b1, 1'b0, 1'b1);

        // Pulse ends
        drive(1'b1, 1'b1, 2'b11, 1'b0, 32'h0, 1'b0, 32'h0); step();
        chk_both("mis_clr", 32'h3002, 32'h3000, 1'b1, 1'b0, 1'b0);

        // Misaligned trap target rejected
        drive(1'b1, 1'b1, 2'b11, 1'b0, 32'h0, 1'b1, 32'h0000_4001); step();
        chk_both("mis_trap", 32'h3002, 32'h3000, 1'b1, 1'b1, 1'b1);

        // Wrap
        drive(1'b0, 1'b1, 2'b11, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0); step();
        chk_both("wrap_ld", 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0);
        redirect_valid_i = 1'b0; step();
        chk_both("wrap", 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        step();
        chk_both("post_wrap", 32'h4, 32'h4, 1'b1, 1'b0, 1'b0);

        // Async reset mid-cycle, with a pending redirect
        redirect_valid_i = 1'b1; redirect_pc_i = 32'h6000;
        #2;
        rst_n = 1'b0;
        #1;
        chk_both("async_rst", 32'h1000, 32'h1000, 1'b0, 1'b0, 1'b0);
        step();
        rst_n = 1'b1;
        #1;
        chk_both("reboot", 32'h1000, 32'h1000, 1'b0, 1'b0, 1'b0);
        step();
        chk_both("rerun", 32'h1000, 32'h1000, 1'b1, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
